// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback unit
package wb_pkg;

    localparam int WB_XLEN   = 32;
    localparam int WB_REG_AW = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                 vld;
        logic [WB_REG_AW-1:0] rd;
        logic [WB_XLEN-1:0]   res;
    } wb_hist_t;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - MEM/WB pipeline register and data-memory response bus
interface writeback_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              mem_wb_valid;
    logic              mem_wb_ready;
    logic [1:0]        mem_wb_sel;
    logic [XLEN-1:0]   mem_wb_alures;
    logic [XLEN-1:0]   mem_wb_pc4;
    logic [2:0]        mem_wb_funct3;
    logic [1:0]        mem_wb_addr_lo;
    logic              mem_wb_regwrite;
    logic [REG_AW-1:0] mem_wb_rd;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_rready;

    // master: pipeline and data memory; slave: the writeback unit
    modport master (
        output mem_wb_valid, mem_wb_sel, mem_wb_alures, mem_wb_pc4,
               mem_wb_funct3, mem_wb_addr_lo, mem_wb_regwrite, mem_wb_rd,
               dmem_rvalid, dmem_rdata,
        input  mem_wb_ready, dmem_rready
    );

    modport slave (
        input  mem_wb_valid, mem_wb_sel, mem_wb_alures, mem_wb_pc4,
               mem_wb_funct3, mem_wb_addr_lo, mem_wb_regwrite, mem_wb_rd,
               dmem_rvalid, dmem_rdata,
        output mem_wb_ready, dmem_rready
    );
endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - selects the addressed byte/halfword of a load word and extends it
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        // halfwords are assumed aligned, so only the upper offset bit picks the lane
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   ext = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_v};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage with load stall FSM, write history and ID forwarding; WB_PERF_CNT_EN adds counters
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_AW     = WB_REG_AW,
    parameter int HIST_DEPTH = 2
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              debug,
    writeback_unit_if.slave   bus,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_res,
    output logic              wb_id_regwrite,
    output logic [REG_AW-1:0] wb_id_rd,
    output logic [XLEN-1:0]   wb_id_res,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              id_rs1_hit,
    output logic              id_rs2_hit,
    output logic [XLEN-1:0]   id_rs1_data,
    output logic [XLEN-1:0]   id_rs2_data,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_ldstall
);

    wb_state_e       state_q, state_d;
    logic            is_load;
    logic            commit;
    logic [XLEN-1:0] load_ext;
    wb_hist_t        hist [HIST_DEPTH];

    wb_load_align #(.XLEN(XLEN)) u_align (
        .rdata   (bus.dmem_rdata),
        .funct3  (bus.mem_wb_funct3),
        .addr_lo (bus.mem_wb_addr_lo),
        .ext     (load_ext)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // reset also blocks commit so a load abandoned in WAIT_MEM is never accepted
    always_comb begin
        state_d          = state_q;
        is_load          = bus.mem_wb_valid && (bus.mem_wb_sel == 2'(WB_MEM));
        commit           = !Rst && !debug && bus.mem_wb_valid && (!is_load || bus.dmem_rvalid);
        bus.mem_wb_ready = !Rst && !debug && (!bus.mem_wb_valid || commit);
        bus.dmem_rready  = commit && is_load;
        case (state_q)
            WB_IDLE: begin
                if (!debug && is_load && !bus.dmem_rvalid) begin
                    state_d = WB_WAIT_MEM;
                end
            end
            WB_WAIT_MEM: begin
                if (commit) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        case (bus.mem_wb_sel)
            2'(WB_MEM): wb_res = load_ext;
            2'(WB_PC4): wb_res = bus.mem_wb_pc4;
            default:    wb_res = bus.mem_wb_alures;
        endcase
        wb_rd = bus.mem_wb_rd;
        wb_we = commit && bus.mem_wb_regwrite && (bus.mem_wb_rd != '0);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (wb_we) begin
            hist[0] <= '{vld: 1'b1, rd: wb_rd, res: wb_res};
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    assign wb_id_regwrite = hist[0].vld;
    assign wb_id_rd       = hist[0].rd;
    assign wb_id_res      = hist[0].res;

    // oldest entries are visited first so newer matches overwrite them
    function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] rs);
        logic [XLEN:0] r;
        r = '0;
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (hist[i].vld && hist[i].rd == rs) begin
                r = {1'b1, hist[i].res};
            end
        end
        if (wb_we && wb_rd == rs) begin
            r = {1'b1, wb_res};
        end
        if (rs == '0) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        {id_rs1_hit, id_rs1_data} = lookup(id_rs1);
        {id_rs2_hit, id_rs2_data} = lookup(id_rs2);
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] ldstall_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            retired_q <= '0;
            ldstall_q <= '0;
        end else begin
            if (commit) begin
                retired_q <= retired_q + 32'd1;
            end
            if (state_q == WB_WAIT_MEM && !debug) begin
                ldstall_q <= ldstall_q + 32'd1;
            end
        end
    end

    assign perf_retired = retired_q;
    assign perf_ldstall = ldstall_q;
`else
    assign perf_retired = '0;
    assign perf_ldstall = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;
    import wb_pkg::*;

`ifdef WB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        Rst;
    logic        debug;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        wb_id_regwrite;
    logic [4:0]  wb_id_rd;
    logic [31:0] wb_id_res;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_hit;
    logic        id_rs2_hit;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] perf_retired;
    logic [31:0] perf_ldstall;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit_if #(.XLEN(32), .REG_AW(5)) bus ();

    writeback_unit #(.XLEN(32), .REG_AW(5), .HIST_DEPTH(2)) dut (
        .clk            (clk),
        .Rst            (Rst),
        .debug          (debug),
        .bus            (bus),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_res         (wb_res),
        .wb_id_regwrite (wb_id_regwrite),
        .wb_id_rd       (wb_id_rd),
        .wb_id_res      (wb_id_res),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_hit     (id_rs1_hit),
        .id_rs2_hit     (id_rs2_hit),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .perf_retired   (perf_retired),
        .perf_ldstall   (perf_ldstall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                      input logic [4:0] rd, input logic [31:0] alu, input logic rv,
                      input logic [31:0] rdat);
        bus.mem_wb_valid    = 1'b1;
        bus.mem_wb_sel      = sel;
        bus.mem_wb_funct3   = f3;
        bus.mem_wb_addr_lo  = alo;
        bus.mem_wb_regwrite = 1'b1;
        bus.mem_wb_rd       = rd;
        bus.mem_wb_alures   = alu;
        bus.dmem_rvalid     = rv;
        bus.dmem_rdata      = rdat;
    endtask

    initial begin
        Rst = 1'b1; debug = 1'b0; id_rs1 = '0; id_rs2 = '0;
        bus.mem_wb_valid = 1'b0; bus.mem_wb_sel = 2'b00; bus.mem_wb_alures = '0;
        bus.mem_wb_pc4 = 32'h0000_1004; bus.mem_wb_funct3 = '0; bus.mem_wb_addr_lo = '0;
        bus.mem_wb_regwrite = 1'b0; bus.mem_wb_rd = '0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        tick(); tick();
        chk("rst_id_regwrite", 32'(wb_id_regwrite), 32'd0);
        chk("rst_id_rd", 32'(wb_id_rd), 32'd0);
        chk("rst_id_res", wb_id_res, 32'd0);
        chk("rst_retired", perf_retired, 32'd0);
        Rst = 1'b0;
        #1;
        chk("idle_ready", 32'(bus.mem_wb_ready), 32'd1);

        // LB / LBU at byte offset 1
        op(2'b01, F3_LB, 2'd1, 5'd3, 32'h0, 1'b1, 32'h0000_8000);
        #1;
        chk("lb_res", wb_res, 32'hFFFF_FF80);
        chk("lb_rready", 32'(bus.dmem_rready), 32'd1);
        chk("lb_ready", 32'(bus.mem_wb_ready), 32'd1);
        chk("lb_we", 32'(wb_we), 32'd1);
        tick();
        chk("lb_id_rd", 32'(wb_id_rd), 32'd3);
        chk("lb_id_res", wb_id_res, 32'hFFFF_FF80);
        op(2'b01, F3_LBU, 2'd1, 5'd4, 32'h0, 1'b1, 32'h0000_8000);
        #1;
        chk("lbu_res", wb_res, 32'h0000_0080);
        tick();

        // PC+4 source, not written (regwrite low)
        op(2'b10, F3_LW, 2'd0, 5'd12, 32'h0, 1'b0, 32'h0);
        bus.mem_wb_regwrite = 1'b0;
        #1;
        chk("pc4_res", wb_res, 32'h0000_1004);
        chk("pc4_we", 32'(wb_we), 32'd0);
        tick();

        // LH with three wait cycles
        op(2'b01, F3_LH, 2'd2, 5'd8, 32'h0, 1'b0, 32'h1234_ABCD);
        #1;
        chk("lh_ready_c1", 32'(bus.mem_wb_ready), 32'd0);
        chk("lh_rready_c1", 32'(bus.dmem_rready), 32'd0);
        tick();
        chk("lh_ready_c2", 32'(bus.mem_wb_ready), 32'd0);
        tick();
        chk("lh_ready_c3", 32'(bus.mem_wb_ready), 32'd0);
        tick();
        bus.dmem_rvalid = 1'b1;
        #1;
        chk("lh_ready_c4", 32'(bus.mem_wb_ready), 32'd1);
        chk("lh_res", wb_res, 32'h0000_1234);
        chk("lh_we", 32'(wb_we), 32'd1);
        tick();
        chk("lh_ldstall", perf_ldstall, PERF ? 32'd3 : 32'd0);
        chk("lh_retired", perf_retired, PERF ? 32'd4 : 32'd0);

        // write to x0 is discarded
        op(2'b00, F3_LW, 2'd0, 5'd0, 32'h55, 1'b0, 32'h0);
        id_rs1 = 5'd0;
        #1;
        chk("x0_we", 32'(wb_we), 32'd0);
        chk("x0_hit", 32'(id_rs1_hit), 32'd0);
        chk("x0_data", id_rs1_data, 32'd0);
        tick();
        chk("x0_id_rd", 32'(wb_id_rd), 32'd8);
        chk("x0_id_res", wb_id_res, 32'h0000_1234);

        // history and forwarding
        op(2'b00, F3_LW, 2'd0, 5'd5, 32'd1, 1'b0, 32'h0); tick();
        op(2'b00, F3_LW, 2'd0, 5'd5, 32'd2, 1'b0, 32'h0); tick();
        op(2'b00, F3_LW, 2'd0, 5'd6, 32'd3, 1'b0, 32'h0); tick();
        bus.mem_wb_valid = 1'b0;
        id_rs1 = 5'd5; id_rs2 = 5'd7;
        #1;
        chk("fwd_rs1_hit", 32'(id_rs1_hit), 32'd1);
        chk("fwd_rs1_data", id_rs1_data, 32'd2);
        chk("fwd_rs2_hit", 32'(id_rs2_hit), 32'd0);
        chk("fwd_rs2_data", id_rs2_data, 32'd0);
        op(2'b00, F3_LW, 2'd0, 5'd6, 32'd4, 1'b0, 32'h0);
        id_rs1 = 5'd6;
        #1;
        chk("fwd_bypass_hit", 32'(id_rs1_hit), 32'd1);
        chk("fwd_bypass_data", id_rs1_data, 32'd4);
        tick();
        bus.mem_wb_valid = 1'b0;
        id_rs1 = 5'd5; id_rs2 = 5'd6;
        #1;
        chk("fwd_dropped_hit", 32'(id_rs1_hit), 32'd0);
        chk("fwd_x6_data", id_rs2_data, 32'd4);
        chk("fwd_retired", perf_retired, PERF ? 32'd9 : 32'd0);

        // debug freeze
        debug = 1'b1;
        op(2'b00, F3_LW, 2'd0, 5'd9, 32'h77, 1'b1, 32'h0);
        #1;
        chk("dbg_ready", 32'(bus.mem_wb_ready), 32'd0);
        chk("dbg_rready", 32'(bus.dmem_rready), 32'd0);
        chk("dbg_we", 32'(wb_we), 32'd0);
        tick();
        chk("dbg_id_rd", 32'(wb_id_rd), 32'd6);
        chk("dbg_id_res", wb_id_res, 32'd4);
        debug = 1'b0;
        #1;
        chk("undbg_we", 32'(wb_we), 32'd1);
        chk("undbg_ready", 32'(bus.mem_wb_ready), 32'd1);
        tick();
        chk("undbg_id_rd", 32'(wb_id_rd), 32'd9);
        chk("undbg_id_res", wb_id_res, 32'h77);

        // reset while waiting on a load
        op(2'b01, F3_LW, 2'd0, 5'd10, 32'h0, 1'b0, 32'hDEAD_BEEF);
        tick();
        Rst = 1'b1;
        bus.dmem_rvalid = 1'b1;
        #1;
        chk("rst_wait_rready", 32'(bus.dmem_rready), 32'd0);
        chk("rst_wait_we", 32'(wb_we), 32'd0);
        tick();
        Rst = 1'b0;
        bus.mem_wb_valid = 1'b0; bus.dmem_rvalid = 1'b0;
        id_rs1 = 5'd9; id_rs2 = 5'd6;
        #1;
        chk("rst2_id_regwrite", 32'(wb_id_regwrite), 32'd0);
        chk("rst2_id_rd", 32'(wb_id_rd), 32'd0);
        chk("rst2_id_res", wb_id_res, 32'd0);
        chk("rst2_rs1_hit", 32'(id_rs1_hit), 32'd0);
        chk("rst2_rs2_hit", 32'(id_rs2_hit), 32'd0);
        chk("rst2_rready", 32'(bus.dmem_rready), 32'd0);
        chk("rst2_ldstall", perf_ldstall, 32'd0);
        chk("rst2_retired", perf_retired, 32'd0);

        // a stall started from IDLE only counts once the FSM is in WAIT_MEM
        op(2'b01, F3_LW, 2'd0, 5'd11, 32'h0, 1'b0, 32'h0);
        tick();
        chk("idle_ldstall", perf_ldstall, 32'd0);
        tick();
        chk("wait_ldstall", perf_ldstall, PERF ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Parametrised successor of the pipeline writeback stage.
- Selects the result from ALU, load data or PC+4.
- Aligns and sign- or zero-extends sub-word loads.
- Stalls MEM/WB on variable-latency data-memory responses with a two-state FSM.
- Holds a HIST_DEPTH-deep history of retired register writes and answers two ID-stage forwarding lookups.

Parameters:
XLEN, 32, datapath width (32 only; 64 reserved)
REG_AW, 5, register address width
HIST_DEPTH, 2, retired-write history entries (1..8)

Ports:
clk  in  1  clock, rising edge
Rst  in  1  synchronous active-high reset
debug  in  1  freeze: no commit, no state or history change
mem_wb_valid  in  1  MEM/WB holds an instruction
mem_wb_ready  out  1  instruction consumed this cycle; upstream holds all mem_wb_* stable while low
mem_wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 PC4, 11 ALU
mem_wb_alures  in  XLEN  ALU result
mem_wb_pc4  in  XLEN  PC+4
mem_wb_funct3  in  3  load type
mem_wb_addr_lo  in  2  load byte offset
mem_wb_regwrite  in  1  writes rd
mem_wb_rd  in  REG_AW  destination
dmem_rvalid  in  1  load data valid; held until accepted
dmem_rdata  in  XLEN  raw load word
dmem_rready  out  1  load data accepted
wb_we  out  1  regfile write enable (comb)
wb_rd  out  REG_AW  regfile address (comb)
wb_res  out  XLEN  regfile data (comb)
wb_id_regwrite, wb_id_rd, wb_id_res  out  1/REG_AW/XLEN  newest history entry (registered)
id_rs1, id_rs2  in  REG_AW  lookup addresses
id_rs1_hit, id_rs2_hit  out  1  forwarding hit
id_rs1_data, id_rs2_data  out  XLEN  forwarded value
perf_retired, perf_ldstall  out  32  counters (see Optional Feature)

Behaviour:
- FSM states IDLE and WAIT_MEM; both reset to IDLE.
- is_load = mem_wb_valid & mem_wb_sel==01.
- commit = !debug & mem_wb_valid & (!is_load | dmem_rvalid).
- mem_wb_ready = !debug & (!mem_wb_valid | commit).
- dmem_rready = commit & is_load.
- IDLE->WAIT_MEM when !debug & is_load & !dmem_rvalid. WAIT_MEM->IDLE on commit. debug holds state.
- Load extension, funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other code behaves as LW.
- Byte lane = addr_lo. Half lane = addr_lo[1]; addr_lo[0] is ignored for halfwords.
- wb_we = commit & mem_wb_regwrite & (mem_wb_rd!=0). wb_rd and wb_res are combinational, zero-latency.
- History is a shift register of {vld, rd, res}. On each wb_we cycle the new write enters entry 0 and the other entries shift; the oldest entry drops. No shift otherwise.
- wb_id_* mirror entry 0.
- Lookup, priority order:
  - current-cycle wb_we write;
  - then entries 0..HIST_DEPTH-1, newest first;
  - first entry with vld & rd==rs wins.
  - rs==0 or no match -> hit=0, data=0.
- Reset: all history vld=0, rd=0, res=0; wb_id_* = 0; counters = 0; state IDLE. Rst overrides debug.
- Rst asserted in WAIT_MEM: the pending load is abandoned and dmem_rready stays 0.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined: perf_retired increments on each commit. perf_ldstall increments on each cycle in WAIT_MEM with !debug. Both wrap at 2^32 and clear on Rst.
- Undefined: both ports are tied 0 and no counter flops exist.

Decomposition:
- Package wb_pkg holds:
  - wb_sel_e {WB_ALU, WB_MEM, WB_PC4};
  - wb_state_e {WB_IDLE, WB_WAIT_MEM};
  - load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - hist entry struct.
- Sub-module wb_load_align: combinational; inputs rdata, funct3, addr_lo; output the extended word.

Test Plan:
- LB, addr_lo=1, rdata=0x0000_8000, rvalid=1 -> same-cycle commit, wb_res=0xFFFF_FF80, dmem_rready=1. Repeat as LBU -> 0x0000_0080.
- LH at addr_lo=2, rdata 0x1234_ABCD, rvalid low 3 cycles -> ready=0 for 3 cycles, perf_ldstall=3, commit in cycle 4 with wb_res=0x0000_1234.
- rd=0, regwrite=1, ALU 0x55 -> wb_we=0, history unchanged, lookup rs1=0 hit=0.
- HIST_DEPTH=2; writes x5=1, x5=2, x6=3:
  - rs1=5 -> hit, data 2;
  - rs2=7 -> miss, data 0;
  - fourth write x6=4 with lookup rs1=6 in the same cycle -> data 4.
- debug=1 with valid ALU op and rvalid pending -> no commit, ready=0, rready=0, history frozen. Release debug -> commit next cycle.
- Rst pulse while in WAIT_MEM -> IDLE next cycle, wb_id_* = 0, all hits 0, dmem_rready=0.
